// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the compressed-ISA fetch front end:
//   fetch_state_e  - alignment state of the fetch sequencer
//   OP32_TAG       - low two bits that mark the first halfword of a 32-bit op
//   swap_bytes32   - converts I-cache raw byte order into the instruction view
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,  // next instruction starts at the low half of the word
    UPPER   = 2'd1,  // next instruction starts at the high half of the word
    SPLIT   = 2'd2   // low half of the word completes a held upper half
  } fetch_state_e;

  localparam logic [1:0] OP32_TAG = 2'b11;

  // The cache returns bytes with the lowest address in the top byte lane.
  function automatic logic [31:0] swap_bytes32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/fetch_half_sel.sv
// ---------------------------------------------------------------------------
// fetch_half_sel
// Combinational halfword selector. Picks the halfword of the current word
// that the sequencer consumes in the given state and classifies it.
// Ports:
//   w_i        in  32  byte-swapped fetch word
//   fsm_i      in  2   sequencer state
//   half_o     out 16  halfword consumed in this state
//   is32_o     out 1   the consumed halfword belongs to a 32-bit instruction
//   straddle_o out 1   a 32-bit instruction starts in the high half and
//                      continues into the next word
// ---------------------------------------------------------------------------
module fetch_half_sel
  import fetch_pkg::*;
(
  input  logic [31:0]  w_i,
  input  fetch_state_e fsm_i,
  output logic [15:0]  half_o,
  output logic         is32_o,
  output logic         straddle_o
);

  logic [15:0] lo_s;
  logic [15:0] hi_s;

  assign lo_s = w_i[15:0];
  assign hi_s = w_i[31:16];

  // Select and classify the halfword for the current alignment state
  always_comb begin
    half_o     = lo_s;
    is32_o     = 1'b0;
    straddle_o = 1'b0;
    case (fsm_i)
      ALIGNED: begin
        half_o = lo_s;
        // An all-zero word is taken as one 32-bit instruction so the
        // illegal pattern reaches decode as a single unit.
        is32_o = (lo_s[1:0] == OP32_TAG) || (w_i == 32'h0000_0000);
      end
      UPPER: begin
        half_o     = hi_s;
        is32_o     = (hi_s[1:0] == OP32_TAG);
        straddle_o = (hi_s[1:0] == OP32_TAG);
      end
      SPLIT: begin
        // Low half is the second half of the held instruction.
        half_o = lo_s;
        is32_o = 1'b1;
      end
      default: begin
        half_o     = lo_s;
        is32_o     = 1'b0;
        straddle_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_align_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_align_ctrl
// Fetch sequencer for the compressed-ISA front end. Owns the fetch PC, drives
// the I-cache word address, splits returned words into halfwords and
// re-assembles 32-bit instructions that straddle word boundaries. Emits one
// aligned raw instruction per cycle (registered).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           freezes all state (redirect still wins)
//   redirect_valid  redirect fetch to redirect_pc (halfword aligned)
//   icache_addr     word fetch address, combinational from state
//   icache_rdata    raw-byte-order data for icache_addr, same cycle
//   instr_o         raw instruction; compressed form is {16'h0, half}
//   pc_o            byte PC of instr_o (holds during bubbles)
//   valid_o         instr_o is a real instruction
//   is_compress_o   instr_o holds a 16-bit instruction
// ---------------------------------------------------------------------------
module fetch_align_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic [31:0]       icache_rdata,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  output logic              is_compress_o
);

  localparam int unsigned       FW_W   = ADDR_W - 2;
  localparam logic [FW_W-1:0]   FW_ONE = {{(FW_W-1){1'b0}}, 1'b1};

  fetch_state_e      fsm_q,        fsm_d;
  logic [FW_W-1:0]   fetch_word_q, fetch_word_d;
  logic [15:0]       hold_half_q,  hold_half_d;
  logic [ADDR_W-1:0] hold_pc_q,    hold_pc_d;
  logic [31:0]       instr_q,      instr_d;
  logic [ADDR_W-1:0] pc_q,         pc_d;
  logic              valid_q,      valid_d;
  logic              comp_q,       comp_d;

  logic [31:0]       w_s;
  logic [15:0]       half_s;
  logic              is32_s;
  logic              straddle_s;
  logic [ADDR_W-1:0] addr_lo_s;
  logic [ADDR_W-1:0] addr_hi_s;
  logic              unused_redirect_bit0;

  // Bit 0 of the redirect target is meaningless for halfword-aligned code.
  assign unused_redirect_bit0 = redirect_pc[0];

  assign w_s         = swap_bytes32(icache_rdata);
  assign addr_lo_s   = {fetch_word_q, 2'b00};
  assign addr_hi_s   = {fetch_word_q, 2'b10};
  assign icache_addr = addr_lo_s;

  fetch_half_sel u_half_sel (
    .w_i        (w_s),
    .fsm_i      (fsm_q),
    .half_o     (half_s),
    .is32_o     (is32_s),
    .straddle_o (straddle_s)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= ALIGNED;
      fetch_word_q <= RESET_PC[ADDR_W-1:2];
      hold_half_q  <= 16'h0000;
      hold_pc_q    <= {ADDR_W{1'b0}};
      instr_q      <= 32'h0000_0000;
      pc_q         <= {ADDR_W{1'b0}};
      valid_q      <= 1'b0;
      comp_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      fetch_word_q <= fetch_word_d;
      hold_half_q  <= hold_half_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      comp_q       <= comp_d;
    end
  end

  // Next-state logic: fetch address, alignment state and held half
  always_comb begin
    fsm_d        = fsm_q;
    fetch_word_d = fetch_word_q;
    hold_half_d  = hold_half_q;
    hold_pc_d    = hold_pc_q;
    if (redirect_valid) begin
      // Redirect wins over stall; any half-assembled instruction is dropped.
      fetch_word_d = redirect_pc[ADDR_W-1:2];
      fsm_d        = redirect_pc[1] ? UPPER : ALIGNED;
      hold_half_d  = 16'h0000;
    end else if (stall) begin
      fsm_d        = fsm_q;
      fetch_word_d = fetch_word_q;
    end else begin
      case (fsm_q)
        ALIGNED: begin
          if (is32_s) begin
            fetch_word_d = fetch_word_q + FW_ONE;
          end else begin
            fsm_d = UPPER;
          end
        end
        UPPER: begin
          fetch_word_d = fetch_word_q + FW_ONE;
          if (straddle_s) begin
            hold_half_d = half_s;
            hold_pc_d   = addr_hi_s;
            fsm_d       = SPLIT;
          end else begin
            fsm_d = ALIGNED;
          end
        end
        SPLIT: begin
          // The following high half still needs decoding: stay on this word.
          hold_half_d = 16'h0000;
          fsm_d       = UPPER;
        end
        default: begin
          fsm_d = ALIGNED;
        end
      endcase
    end
  end

  // Output logic: value to register into the instruction outputs
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    comp_d  = comp_q;
    if (redirect_valid) begin
      // Kill the emission; pc_o keeps its last value like any bubble.
      instr_d = 32'h0000_0000;
      valid_d = 1'b0;
      comp_d  = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      case (fsm_q)
        ALIGNED: begin
          instr_d = is32_s ? w_s : {16'h0000, half_s};
          pc_d    = addr_lo_s;
          valid_d = 1'b1;
          comp_d  = ~is32_s;
        end
        UPPER: begin
          if (straddle_s) begin
            instr_d = 32'h0000_0000;
            valid_d = 1'b0;
            comp_d  = 1'b0;
          end else begin
            instr_d = {16'h0000, half_s};
            pc_d    = addr_hi_s;
            valid_d = 1'b1;
            comp_d  = 1'b1;
          end
        end
        SPLIT: begin
          instr_d = {half_s, hold_half_q};
          pc_d    = hold_pc_q;
          valid_d = 1'b1;
          comp_d  = 1'b0;
        end
        default: begin
          instr_d = 32'h0000_0000;
          valid_d = 1'b0;
          comp_d  = 1'b0;
        end
      endcase
    end
  end

  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign valid_o       = valid_q;
  assign is_compress_o = comp_q;

endmodule
